// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one single-port, synchronous-read sprite/background ROM among
//   several pixel-path requesters. Requester 0 (background fetch) always
//   wins. The other requesters take turns in round-robin order whenever
//   requester 0 is idle. ROM data comes back tagged to the granted
//   requester one clock after the grant. Low-priority requesters that wait
//   too long are reported through sticky starve flags.
//
// Ports
//   clk        pixel clock
//   rst        asynchronous active-low reset (0 = reset)
//   req        per-requester request, held with a stable address until granted
//   req_addr   packed addresses, requester k at [k*ADDR_BITS +: ADDR_BITS]
//   gnt        one-hot grant, combinational, same cycle as acceptance
//   rom_addr   granted address to the ROM, 0 when idle
//   rom_en     ROM read enable, high when any grant is high
//   rom_data   ROM read data, valid one clock after rom_addr is sampled
//   rsp_valid  registered one-hot response strobe, one cycle after gnt
//   rsp_data   ROM data passed through, meaningful with any rsp_valid bit
//   starve     sticky starvation flags, bit 0 is always 0
//   clr_starve synchronous clear of all starve flags
module sprite_rom_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_BITS    = 13,
    parameter int DATA_BITS    = 6,
    parameter int STARVE_LIMIT = 200
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [ADDR_BITS-1:0]           rom_addr,
    output logic                           rom_en,
    input  logic [DATA_BITS-1:0]           rom_data,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_BITS-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]             starve,
    input  logic                           clr_starve
);

    localparam int         PTR_W = $clog2(NUM_REQ);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Round-robin pointer: the first low-priority index to consider.
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]         starve_q, starve_d;
    logic [NUM_REQ-1:1][7:0]    wait_cnt_q, wait_cnt_d;

    logic [PTR_W-1:0]           sel_lo, sel_hi, sel_idx;
    logic                       any_lo, any_hi;
    logic [NUM_REQ-1:0]         gnt_raw;

    // Round-robin search without a wrapping index: sel_hi is the lowest
    // requesting index at or above the pointer, sel_lo the lowest requesting
    // index overall. If nothing sits at/above the pointer the search has
    // wrapped, and sel_lo is the answer.
    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        any_lo = 1'b0;
        any_hi = 1'b0;
        for (int k = NUM_REQ-1; k >= 1; k--) begin
            if (req[k]) begin
                sel_lo = PTR_W'(k);
                any_lo = 1'b1;
                if (PTR_W'(k) >= rr_ptr_q) begin
                    sel_hi = PTR_W'(k);
                    any_hi = 1'b1;
                end
            end
        end
        sel_idx = any_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        gnt_raw = '0;
        if (req[0]) begin
            gnt_raw[0] = 1'b1;
        end else if (any_lo) begin
            for (int k = 1; k < NUM_REQ; k++) begin
                gnt_raw[k] = (sel_idx == PTR_W'(k));
            end
        end
    end

    // Nothing is granted while reset is asserted.
    assign gnt    = rst ? gnt_raw : '0;
    assign rom_en = |gnt;

    always_comb begin
        rom_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                rom_addr = req_addr[k*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Pointer only moves on a low-priority grant; it skips past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!req[0] && any_lo) begin
            if (sel_idx == PTR_W'(NUM_REQ-1)) begin
                rr_ptr_d = PTR_W'(1);
            end else begin
                rr_ptr_d = sel_idx + PTR_W'(1);
            end
        end
    end

    assign rsp_valid_d = gnt;

    // Wait counters saturate at the limit; starvation is flagged from the
    // registered count, and a set in the same cycle as clr_starve wins.
    always_comb begin
        wait_cnt_d = '0;
        starve_d   = clr_starve ? '0 : starve_q;
        for (int k = 1; k < NUM_REQ; k++) begin
            if (req[k] && !gnt[k]) begin
                wait_cnt_d[k] = (wait_cnt_q[k] == LIMIT) ? LIMIT
                                                         : wait_cnt_q[k] + 8'd1;
            end
            if (wait_cnt_q[k] == LIMIT) begin
                starve_d[k] = 1'b1;
            end
        end
        starve_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= PTR_W'(1);
            rsp_valid_q <= '0;
            starve_q    <= '0;
            wait_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            starve_q    <= starve_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rom_data;
    assign starve    = starve_q;

    gnt_onehot_a : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));

endmodule
